data_memory_sized: RTL and testbench

Parametrised successor to the single-cycle data RAM for the MIPS datapath. It adds byte, halfword and word access with sign/zero extension, and a registered one-cycle read path with a request/response handshake. It also detects misaligned and out-of-range accesses, and clears memory with a hardware sweep FSM after reset or on demand. It sits between the load/store unit of the pipelined core and the word-organised storage array.

---
 rtl/data_memory_sized.sv | 158 +++++++++++++++
 tb/tb_data_memory_sized.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_sized.sv
// Word-organised data RAM with byte/half/word loads and stores, a registered one-cycle
// response path, fault detection, and a hardware clear sweep after reset or on request.
module data_memory_sized #(
    parameter int ADDR_WIDTH     = 32,
    parameter int CELLS_NUMBER   = 128,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_clear,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [31:0]           i_write_data,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_resp_valid,
    output logic [31:0]           o_read_data,
    output logic                  o_fault
);

    localparam int IDX_W = $clog2(CELLS_NUMBER);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS_NUMBER - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t state, state_next;
    logic [IDX_W-1:0] clear_cnt, clear_cnt_next;

    logic [31:0] mem [CELLS_NUMBER];

    logic [ADDR_WIDTH-3:0] word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic [1:0]            lane;
    logic                  in_range;
    logic                  size_fault;
    logic                  req_fault;
    logic                  accept;
    logic [3:0]            byte_en;
    logic [31:0]           wdata_lane;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [31:0]           load_ext;

    assign word_idx = i_address[ADDR_WIDTH-1:2];
    assign lane     = i_address[1:0];
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = ({2'b00, word_idx} < ADDR_WIDTH'(CELLS_NUMBER));

    assign o_ready = (state == ST_IDLE);
    assign o_busy  = (state == ST_CLEAR);
    assign accept  = i_req & o_ready & ~i_clear;

    always_comb begin
        size_fault = 1'b0;
        case (i_size)
            2'b00:   size_fault = 1'b0;
            2'b01:   size_fault = i_address[0];
            2'b10:   size_fault = |i_address[1:0];
            default: size_fault = 1'b1;
        endcase
    end

    assign req_fault = size_fault | ~in_range;

    // Store data and byte enables are moved up to the addressed lane.
    always_comb begin
        byte_en = 4'b0000;
        case (i_size)
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = 4'b0011 << lane;
            default: byte_en = 4'b1111;
        endcase
    end

    assign wdata_lane = i_write_data << {lane, 3'b000};

    assign rd_word  = mem[mem_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        load_ext = rd_shift;
        case (i_size)
            2'b00:   load_ext = i_unsigned ? {24'h0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_ext = i_unsigned ? {16'h0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_next     = state;
        clear_cnt_next = clear_cnt;
        case (state)
            ST_CLEAR: begin
                if (i_clear) begin
                    clear_cnt_next = '0;
                end else if (clear_cnt == LAST_IDX) begin
                    clear_cnt_next = '0;
                    state_next     = ST_IDLE;
                end else begin
                    clear_cnt_next = clear_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (i_clear) begin
                    state_next     = ST_CLEAR;
                    clear_cnt_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clear_cnt <= '0;
        end else begin
            state     <= state_next;
            clear_cnt <= clear_cnt_next;
        end
    end

    // The array has no reset; the sweep is the only way it is zeroed.
    always_ff @(posedge i_clk) begin
        if (state == ST_CLEAR) begin
            mem[clear_cnt] <= 32'h0;
        end else if (accept && i_we && !req_fault) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[mem_idx][8*k +: 8] <= wdata_lane[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_resp_valid <= 1'b0;
            o_read_data  <= 32'h0;
            o_fault      <= 1'b0;
        end else begin
            o_resp_valid <= accept;
            if (accept) begin
                o_fault     <= req_fault;
                o_read_data <= (req_fault || i_we) ? 32'h0 : load_ext;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// Table-driven bench for data_memory_sized with a response scoreboard and
// hand-written clear/reset sequences.
module tb_data_memory_sized;

    localparam int CELLS = 128;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          id;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready;
    logic        busy;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        fault;

    int   vec_count = 0;
    int   miss_count = 0;
    int   cyc = 0;
    int   next_id = 0;
    int   busy_n;
    exp_t exp_q[$];
    vec_t vecs[$];

    data_memory_sized #(
        .ADDR_WIDTH(32),
        .CELLS_NUMBER(CELLS),
        .CLEAR_ON_RESET(1)
    ) dut (
        .i_clk(clk),
        .i_arst_n(rst_n),
        .i_clear(clear),
        .i_req(req),
        .i_we(we),
        .i_size(size),
        .i_unsigned(uns),
        .i_address(addr),
        .i_write_data(wdata),
        .o_ready(ready),
        .o_busy(busy),
        .o_resp_valid(resp_valid),
        .o_read_data(rdata),
        .o_fault(fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] ed, input logic ef);
        vec_t v;
        v.we = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_data = ed; v.exp_fault = ef;
        return v;
    endfunction

    // Drives one request for a single cycle; expects acceptance at the next edge.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        e.data = v.exp_data; e.fault = v.exp_fault; e.id = next_id; e.due = cyc + 1;
        next_id++;
        exp_q.push_back(e);
        req = 1'b1; we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic countBusy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("[TB] FAIL unexpected_resp: got resp_valid=1 data=%h, expected no response", rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput($sformatf("resp%0d_data", e.id), rdata, e.data);
                checkOutput($sformatf("resp%0d_fault", e.id), {31'h0, fault}, {31'h0, e.fault});
                checkOutput($sformatf("resp%0d_cycle", e.id), cyc, e.due);
            end
        end
    end

    initial begin
        vecs.push_back(mk(0, 2'b10, 0, 32'h1FC, 0, 32'h00000000, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h010, 32'h80FF7F01, 32'h0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h010, 0, 32'h00000001, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h011, 0, 32'h0000007F, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h013, 0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h012, 0, 32'h000000FF, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h020, 32'h11223344, 32'h0, 0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h022, 32'h5555BEEF, 32'h0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h020, 0, 32'hBEEF3344, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h022, 0, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h022, 0, 32'h0000BEEF, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h021, 0, 32'h0, 1));
        vecs.push_back(mk(1, 2'b01, 0, 32'h023, 32'h0000AAAA, 32'h0, 1));
        vecs.push_back(mk(0, 2'b11, 0, 32'h000, 0, 32'h0, 1));
        vecs.push_back(mk(0, 2'b10, 0, 32'h200, 0, 32'h0, 1));
        vecs.push_back(mk(0, 2'b10, 1, 32'h020, 0, 32'hBEEF3344, 0));
        vecs.push_back(mk(1, 2'b00, 0, 32'h031, 32'hFFFFFFA5, 32'h0, 0));
        vecs.push_back(mk(0, 2'b10, 0, 32'h030, 0, 32'h0000A500, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h030, 0, 32'h0000A500, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h030, 0, 32'hFFFFA500, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h031, 0, 32'h000000A5, 0));

        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("reset_read_data", rdata, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h1);
        checkOutput("reset_ready", {31'h0, ready}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        countBusy(busy_n);
        checkOutput("init_sweep_len", busy_n, CELLS);
        checkOutput("init_ready", {31'h0, ready}, 32'h1);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
        repeat (3) @(posedge clk);
        #1;

        // Clear request wins over a same-cycle store, which must vanish.
        clear = 1'b1; req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        clear = 1'b0; req = 1'b0;
        countBusy(busy_n);
        checkOutput("clear_sweep_len", busy_n, CELLS);
        checkOutput("clear_ready", {31'h0, ready}, 32'h1);
        @(posedge clk);
        #1;
        applyStimulus(mk(0, 2'b10, 0, 32'h000, 0, 32'h0, 0));
        applyStimulus(mk(0, 2'b10, 0, 32'h020, 0, 32'h0, 0));
        applyStimulus(mk(1, 2'b10, 0, 32'h004, 32'h12345678, 32'h0, 0));
        applyStimulus(mk(0, 2'b10, 0, 32'h004, 0, 32'h12345678, 0));
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a sweep, while read data still holds a nonzero value.
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        repeat (60) @(negedge clk);
        checkOutput("mid_sweep_busy", {31'h0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("midrst_read_data", rdata, 32'h0);
        checkOutput("midrst_fault", {31'h0, fault}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        countBusy(busy_n);
        checkOutput("rst_sweep_len", busy_n, CELLS);
        checkOutput("rst_ready", {31'h0, ready}, 32'h1);
        @(posedge clk);
        #1;
        applyStimulus(mk(0, 2'b10, 0, 32'h004, 0, 32'h0, 0));
        repeat (3) @(posedge clk);
        #1;

        checkOutput("scoreboard_drain", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
